// File: rtl/filterbank_pkg.sv
// Shared constants and FSM state encoding for the filter-bank MAC control path.
package filterbank_pkg;

    localparam int unsigned NTAPS   = 128;
    localparam int unsigned COEF_AW = 6;
    localparam int unsigned SAMP_AW = 7;
    localparam int unsigned MEM_LAT = 1;
    localparam int unsigned MAC_LAT = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } fsm_state_t;

endpackage

// File: rtl/fb_strobe_delay.sv
// DEPTH-stage, WIDTH-bit shift register with asynchronous active-high reset.
module fb_strobe_delay #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned WIDTH = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] pipe [DEPTH];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= d;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign q = pipe[DEPTH-1];

endmodule

// File: rtl/fb_mac_sequencer.sv
// Control sequencer for the 8-filter time-multiplexed FIR bank: sample write,
// coefficient walk, MAC strobes and output-register load.
module fb_mac_sequencer #(
    parameter int unsigned NTAPS   = filterbank_pkg::NTAPS,
    parameter int unsigned COEF_AW = filterbank_pkg::COEF_AW,
    parameter int unsigned SAMP_AW = filterbank_pkg::SAMP_AW,
    parameter int unsigned MEM_LAT = filterbank_pkg::MEM_LAT,
    parameter int unsigned MAC_LAT = filterbank_pkg::MAC_LAT
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               din_enable,
    output logic               samp_we,
    output logic [SAMP_AW-1:0] samp_waddr,
    output logic [SAMP_AW-1:0] samp_raddr0,
    output logic [SAMP_AW-1:0] samp_raddr1,
    output logic [COEF_AW-1:0] coeffaddress,
    output logic               mac_en,
    output logic               mac_clear,
    output logic               mac_last,
    output logic               dout_load,
    output logic               busy,
    output logic               overrun
);

    import filterbank_pkg::*;

    localparam int unsigned        DRAIN_CYC  = MEM_LAT + MAC_LAT;
    localparam logic [COEF_AW-1:0] K_LAST     = COEF_AW'(NTAPS / 2 - 1);
    localparam logic [2:0]         DRAIN_LAST = 3'(DRAIN_CYC - 1);

    fsm_state_t         state;
    fsm_state_t         state_next;
    logic [COEF_AW-1:0] k;
    logic [SAMP_AW-1:0] wptr;
    logic [2:0]         drain_cnt;
    logic               run;
    logic [SAMP_AW-1:0] tap_even;
    logic [2:0]         strobe_raw;
    logic [2:0]         strobe_dly;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (din_enable) state_next = ST_LOAD;
            ST_LOAD:  state_next = ST_RUN;
            ST_RUN:   if (k == K_LAST) state_next = ST_DRAIN;
            ST_DRAIN: if (drain_cnt == DRAIN_LAST) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            k         <= '0;
            wptr      <= '0;
            drain_cnt <= '0;
            overrun   <= 1'b0;
        end else begin
            if (state == ST_RUN) begin
                k <= (k == K_LAST) ? '0 : k + 1'b1;
            end
            if (state == ST_DRAIN) begin
                drain_cnt <= drain_cnt + 1'b1;
            end else begin
                drain_cnt <= '0;
            end
            if (state == ST_DONE) begin
                wptr <= wptr + 1'b1;
            end
            // Any request outside IDLE, the DONE cycle included, is dropped but remembered.
            if (din_enable && state != ST_IDLE) begin
                overrun <= 1'b1;
            end
        end
    end

    // Tap 2k sits 2k entries behind the newest sample; the mod-NTAPS wrap is the natural
    // overflow of the SAMP_AW-bit subtraction.
    assign tap_even = wptr - SAMP_AW'({k, 1'b0});

    always_comb begin
        run          = (state == ST_RUN);
        samp_we      = (state == ST_LOAD);
        samp_waddr   = '0;
        samp_raddr0  = '0;
        samp_raddr1  = '0;
        coeffaddress = '0;
        if (samp_we) begin
            samp_waddr = wptr;
        end
        if (run) begin
            samp_raddr0  = tap_even;
            samp_raddr1  = tap_even - SAMP_AW'(1);
            coeffaddress = k;
        end
        strobe_raw = {run && (k == K_LAST), run && (k == '0), run};
        dout_load  = (state == ST_DONE);
        busy       = (state != ST_IDLE);
    end

    fb_strobe_delay #(
        .DEPTH(MEM_LAT),
        .WIDTH(3)
    ) u_strobe_delay (
        .clock(clock),
        .reset(reset),
        .d    (strobe_raw),
        .q    (strobe_dly)
    );

    assign mac_en    = strobe_dly[0];
    assign mac_clear = strobe_dly[1];
    assign mac_last  = strobe_dly[2];

endmodule

// File: tb/tb_fb_mac_sequencer.sv
// Directed bench for fb_mac_sequencer: strobe timing, addressing, overrun, reset abort,
// and an 8-filter datapath harness scored against a reference FIR.
module tb_fb_mac_sequencer;

    localparam int NF = 8;
    localparam int NT = 128;
    localparam int NW = 64;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic              reset, din_enable;
    logic signed [15:0] datain;
    logic              samp_we, mac_en, mac_clear, mac_last, dout_load, busy, overrun;
    logic [6:0]        samp_waddr, samp_raddr0, samp_raddr1;
    logic [5:0]        coeffaddress;

    logic              reset_b, din_b;
    logic              b_we, b_en, b_clear, b_last, b_load, b_busy, b_overrun;
    logic [6:0]        b_waddr, b_raddr0, b_raddr1;
    logic [5:0]        b_caddr;

    fb_mac_sequencer dut (
        .clock(clock), .reset(reset), .din_enable(din_enable),
        .samp_we(samp_we), .samp_waddr(samp_waddr),
        .samp_raddr0(samp_raddr0), .samp_raddr1(samp_raddr1),
        .coeffaddress(coeffaddress), .mac_en(mac_en), .mac_clear(mac_clear),
        .mac_last(mac_last), .dout_load(dout_load), .busy(busy), .overrun(overrun)
    );

    fb_mac_sequencer #(.MEM_LAT(3), .MAC_LAT(1)) dut_b (
        .clock(clock), .reset(reset_b), .din_enable(din_b),
        .samp_we(b_we), .samp_waddr(b_waddr),
        .samp_raddr0(b_raddr0), .samp_raddr1(b_raddr1),
        .coeffaddress(b_caddr), .mac_en(b_en), .mac_clear(b_clear),
        .mac_last(b_last), .dout_load(b_load), .busy(b_busy), .overrun(b_overrun)
    );

    // Datapath harness: sample RAM, 8 coefficient ROMs (1-clock reads), product register
    // and accumulator (two-stage MAC), all steered only by the sequencer outputs.
    logic signed [15:0] sram [NT];
    logic [35:0]        cmem [NF][NW];
    int                 cf   [NF][NT];
    logic signed [15:0] rd0, rd1;
    logic [35:0]        cw   [NF];
    longint             prod [NF];
    longint             acc  [NF];
    logic               en_d, clr_d;

    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NT; i++) sram[i] <= '0;
            en_d  <= 1'b0;
            clr_d <= 1'b0;
        end else begin
            if (samp_we) sram[samp_waddr] <= datain;
            rd0 <= sram[samp_raddr0];
            rd1 <= sram[samp_raddr1];
            for (int f = 0; f < NF; f++) begin
                cw[f] <= cmem[f][coeffaddress];
                if (mac_en)
                    prod[f] <= longint'($signed(cw[f][17:0])) * longint'(rd0)
                             + longint'($signed(cw[f][35:18])) * longint'(rd1);
                if (en_d) acc[f] <= clr_d ? prod[f] : acc[f] + prod[f];
            end
            en_d  <= mac_en;
            clr_d <= mac_clear;
        end
    end

    logic signed [15:0] hist [$];
    longint             sbq  [$];
    int vectors = 0;
    int fails   = 0;

    int we_cnt, we_n, en_cnt, en_first, en_last, clr_cnt, clr_n;
    int last_cnt, last_n, dl_cnt, dl_n, busy_low_n;
    logic [6:0] waddr_seen, ra0_k1, ra1_k1;
    logic [5:0] ca_k1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    function automatic longint fir(input int f);
        longint s = 0;
        for (int j = 0; j < NT; j++)
            if (j < hist.size()) s += longint'(cf[f][j]) * longint'(hist[j]);
        return s;
    endfunction

    function automatic logic [63:0] outs_a();
        return 64'({samp_we, samp_waddr, samp_raddr0, samp_raddr1, coeffaddress,
                    mac_en, mac_clear, mac_last, dout_load, busy, overrun});
    endfunction

    // One din_enable pulse, then nobs observed cycles. Optional extra pulses at din_a/din_b
    // and a reset assertion at rst_at (held 3 cycles); 0 disables each.
    task automatic send(input logic signed [15:0] x, input bit score, input int nobs,
                        input int din_a, input int din_b, input int rst_at);
        @(posedge clock); #1;
        din_enable = 1'b1;
        datain     = x;
        if (score) begin
            hist.push_front(x);
            if (hist.size() > NT) void'(hist.pop_back());
            for (int f = 0; f < NF; f++) sbq.push_back(fir(f));
        end
        we_cnt = 0; we_n = -1; en_cnt = 0; en_first = -1; en_last = -1;
        clr_cnt = 0; clr_n = -1; last_cnt = 0; last_n = -1;
        dl_cnt = 0; dl_n = -1; busy_low_n = -1; waddr_seen = 'x;
        for (int n = 1; n <= nobs; n++) begin
            @(posedge clock); #1;
            din_enable = (n == din_a) || (n == din_b);
            if (samp_we) begin
                we_cnt++;
                if (we_n < 0) begin we_n = n; waddr_seen = samp_waddr; end
            end
            if (mac_en) begin en_cnt++; if (en_first < 0) en_first = n; en_last = n; end
            if (mac_clear) begin clr_cnt++; clr_n = n; end
            if (mac_last) begin last_cnt++; last_n = n; end
            if (n == 3) begin ra0_k1 = samp_raddr0; ra1_k1 = samp_raddr1; ca_k1 = coeffaddress; end
            if (dout_load) begin
                dl_cnt++;
                dl_n = n;
                for (int f = 0; f < NF; f++)
                    if (sbq.size() != 0) check($sformatf("fir_f%0d", f), acc[f], sbq.pop_front());
            end
            if (!busy && busy_low_n < 0) busy_low_n = n;
            if (rst_at > 0 && n == rst_at) begin
                reset = 1'b1;
                #1;
                check("reset_midrun_outputs", outs_a(), '0);
            end
            if (rst_at > 0 && n == rst_at + 3) reset = 1'b0;
        end
    endtask

    initial begin
        int b_en_cnt, b_en_first, b_en_last, b_clr_n, b_last_n, b_dl_n;
        logic signed [15:0] x;

        reset = 1'b1; reset_b = 1'b1;
        din_enable = 1'b0; din_b = 1'b0; datain = '0;
        for (int f = 0; f < NF; f++) begin
            for (int j = 0; j < NT; j++) cf[f][j] = int'($urandom_range(0, 262143)) - 131072;
            for (int k = 0; k < NW; k++) cmem[f][k] = {18'(cf[f][2*k+1]), 18'(cf[f][2*k])};
        end
        repeat (3) @(posedge clock);
        #1;
        check("reset_outputs_a", outs_a(), '0);
        check("reset_outputs_b", 64'({b_we, b_waddr, b_raddr0, b_raddr1, b_caddr, b_en,
                                      b_clear, b_last, b_load, b_busy, b_overrun}), '0);
        reset = 1'b0; reset_b = 1'b0;

        // Impulse for 64 samples, then a negative step; 130 samples wrap the write pointer.
        for (int i = 0; i < 130; i++) begin
            x = (i == 0) ? 16'sd32767 : ((i >= 64) ? -16'sd12345 : 16'sd0);
            send(x, 1'b1, 70, 0, 0, 0);
            check($sformatf("waddr_s%0d", i), waddr_seen, 64'(i % 128));
            check($sformatf("dout_load_at_s%0d", i), dl_n, 69);
            if (i == 0) begin
                check("we_at", we_n, 1);
                check("we_count", we_cnt, 1);
                check("mac_en_first", en_first, 3);
                check("mac_en_last", en_last, 66);
                check("mac_en_count", en_cnt, 64);
                check("mac_clear_at", clr_n, 3);
                check("mac_clear_count", clr_cnt, 1);
                check("mac_last_at", last_n, 66);
                check("mac_last_count", last_cnt, 1);
                check("dout_load_count", dl_cnt, 1);
                check("busy_low_at", busy_low_n, 70);
            end
            if (i == 1) begin
                check("raddr0_wrap", ra0_k1, 127);
                check("raddr1_wrap", ra1_k1, 126);
                check("coeffaddr_k1", ca_k1, 1);
            end
        end
        check("overrun_clear", overrun, 0);

        // Requests mid-RUN and in the DONE cycle are dropped.
        send(-16'sd12345, 1'b1, 74, 40, 69, 0);
        check("ovr_waddr", waddr_seen, 2);
        check("ovr_we_count", we_cnt, 1);
        check("ovr_mac_en_count", en_cnt, 64);
        check("ovr_dout_load_count", dl_cnt, 1);
        check("ovr_dout_load_at", dl_n, 69);
        check("overrun_set", overrun, 1);
        repeat (5) @(posedge clock);
        #1;
        check("overrun_sticky", overrun, 1);
        check("ovr_idle_busy", busy, 0);

        // Reset mid-RUN aborts the run and rewinds the write pointer.
        send(16'sd1111, 1'b0, 40, 0, 0, 30);
        check("abort_dout_load_count", dl_cnt, 0);
        send(16'sd2222, 1'b0, 70, 0, 0, 0);
        check("after_reset_waddr", waddr_seen, 0);
        check("after_reset_dout_load_at", dl_n, 69);

        // MEM_LAT=3, MAC_LAT=1 instance.
        b_en_cnt = 0; b_en_first = -1; b_en_last = -1; b_clr_n = -1; b_last_n = -1; b_dl_n = -1;
        @(posedge clock); #1;
        din_b = 1'b1;
        for (int n = 1; n <= 72; n++) begin
            @(posedge clock); #1;
            din_b = 1'b0;
            if (b_en) begin b_en_cnt++; if (b_en_first < 0) b_en_first = n; b_en_last = n; end
            if (b_clear) b_clr_n = n;
            if (b_last) b_last_n = n;
            if (b_load && b_dl_n < 0) b_dl_n = n;
        end
        check("b_mac_en_first", b_en_first, 5);
        check("b_mac_en_last", b_en_last, 68);
        check("b_mac_en_count", b_en_cnt, 64);
        check("b_mac_clear_at", b_clr_n, 5);
        check("b_mac_last_at", b_last_n, 68);
        check("b_dout_load_at", b_dl_n, 70);

        check("scoreboard_drained", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
